contador_param: RTL

Parametrised up/down occupancy counter for the access-control datapath. It counts entry events on `x` and exit events on `y` between 0 and a configurable capacity `MAX`. It flags full, empty and near-full conditions, and it records sticky overflow and underflow errors for attempts past either limit. It replaces the fixed 3-bit counter wherever capacity differs from 7 or simultaneous sensor events can occur.

---
 rtl/contador_param.sv | 103 ++++++++++
 1 files changed

// File: rtl/contador_param.sv
// Parametrised up/down occupancy counter with full/empty/near-full flags and sticky
// overflow/underflow errors. Define CONTADOR_EDGE_DET_EN to count rising edges of x/y.
module contador_param #(
    parameter int W     = 4,
    parameter int MAX   = 10,
    parameter int ALARM = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         x,
    input  logic         y,
    input  logic         clr,
    output logic [W-1:0] c,
    output logic         s,
    output logic         empty,
    output logic         alarm,
    output logic         ovf,
    output logic         unf
);

    if (W < 2 || W > 16) begin : g_bad_w
        $error("contador_param: W must be in 2..16");
    end
    if (MAX < 1 || MAX > (1 << W) - 1) begin : g_bad_max
        $error("contador_param: MAX must be in 1..2^W-1");
    end
    if (ALARM < 1 || ALARM > MAX) begin : g_bad_alarm
        $error("contador_param: ALARM must be in 1..MAX");
    end

    localparam logic [W-1:0] MAX_C   = W'(MAX);
    localparam logic [W-1:0] ALARM_C = W'(ALARM);

    logic         inc, dec;
    logic [W-1:0] c_q, c_d;
    logic         ovf_q, ovf_d, unf_q, unf_d;
    logic         s_q, empty_q, alarm_q;

`ifdef CONTADOR_EDGE_DET_EN
    logic x_q, y_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= 1'b0;
            y_q <= 1'b0;
        end else begin
            x_q <= x;
            y_q <= y;
        end
    end

    assign inc = x & ~x_q;
    assign dec = y & ~y_q;
`else
    assign inc = x;
    assign dec = y;
`endif

    // clr wins over events; a simultaneous entry and exit cancel without error
    always_comb begin
        c_d   = c_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr) begin
            c_d   = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (inc && !dec) begin
            if (c_q == MAX_C) ovf_d = 1'b1;
            else              c_d   = c_q + W'(1);
        end else if (dec && !inc) begin
            if (c_q == '0) unf_d = 1'b1;
            else           c_d   = c_q - W'(1);
        end
    end

    // Flags are derived from next-count so they line up with c in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            s_q     <= 1'b0;
            empty_q <= 1'b1;
            alarm_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            s_q     <= (c_d == MAX_C);
            empty_q <= (c_d == '0);
            alarm_q <= (c_d >= ALARM_C);
        end
    end

    assign c     = c_q;
    assign s     = s_q;
    assign empty = empty_q;
    assign alarm = alarm_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
